// File: rtl/alu_addsub_seq.sv
// alu_addsub_seq: walks a WORDS*N-bit add or subtract through an external
// N-bit adder, one chunk per cycle, least significant chunk first. The carry
// is chained through c_reg. The wide result and its carry/overflow/zero flags
// are then offered on a valid/ready output handshake.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | in_ready high; waits for an operand request
//  RUN   | one chunk per edge through the external adder, idx counts up
//  DONE  | out_valid high; result and flags frozen until out_ready
module alu_addsub_seq #(
  parameter int N     = 32,
  parameter int WORDS = 4,
  localparam int W    = N * WORDS,
  localparam int IW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_s,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [IW-1:0]  idx;
  logic           c_reg;
  logic           sub_reg;
  logic           z_run;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic           last;
  logic           s_zero;

  assign last     = (idx == IW'(WORDS - 1));
  assign s_zero   = (add_s == '0);
  assign in_ready = (state == IDLE) && rst_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and adder drive; the adder sees zeros outside RUN
  always_comb begin
    state_nx = state;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN: begin
        add_a   = a_reg[idx*N +: N];
        add_b   = b_reg[idx*N +: N];
        // Subtract is A + ~B + 1: the +1 enters as carry-in on chunk 0
        add_cin = (idx == '0) ? sub_reg : c_reg;
        if (last) state_nx = DONE;
      end
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, chunk-wise result assembly, flag capture and out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      c_reg     <= 1'b0;
      sub_reg   <= 1'b0;
      z_run     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= op_a;
            b_reg   <= sub ? ~op_b : op_b;
            sub_reg <= sub;
            idx     <= '0;
            z_run   <= 1'b1;
          end
        end
        RUN: begin
          result[idx*N +: N] <= add_s;
          c_reg              <= add_cout;
          idx                <= idx + IW'(1);
          z_run              <= z_run & s_zero;
          if (last) begin
            carry     <= add_cout;
            // Uses the effective (inverted for subtract) B sign
            overflow  <= (a_reg[W-1] == b_reg[W-1]) && (add_s[N-1] != a_reg[W-1]);
            zero      <= z_run & s_zero;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Bench for alu_addsub_seq: behavioural external adder, directed vector
// table, randomized operations against a wide-arithmetic model, and
// backpressure / mid-operation reset sequences.
module tb_alu_addsub_seq;

  localparam int N     = 32;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_s;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External combinational adder
  logic [N:0] sum_full;
  assign sum_full = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
  assign add_s    = sum_full[N-1:0];
  assign add_cout = sum_full[N];

  alu_addsub_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain W-bit arithmetic; overflow from a sign-extended result
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic c, output logic o,
                                output logic z);
    logic [W:0] ws;
    if (s) begin
      r = a - b;
      c = (a >= b);
      ws = {a[W-1], a} - {b[W-1], b};
    end else begin
      r = a + b;
      c = ((({1'b0, a} + {1'b0, b}) >> W) != 0);
      ws = {a[W-1], a} + {b[W-1], b};
    end
    o = (ws[W] != ws[W-1]);
    z = (r == '0);
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int k = 0; k < WORDS; k++) begin
      case ($urandom_range(0, 3))
        0:       v[k*N +: N] = '0;
        1:       v[k*N +: N] = '1;
        default: v[k*N +: N] = $urandom;
      endcase
    end
    return v;
  endfunction

  // Waits for out_valid counting edges since the accept edge
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 3 * WORDS) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] er, input logic ec, input logic eo,
                        input logic ez, input string tag);
    int lat;
    logic [W-1:0] beff;
    beff = s ? ~b : b;
    @(negedge clk);
    chk({tag, " in_ready idle"}, in_ready, 1);
    in_valid = 1'b1; op_a = a; op_b = b; sub = s;
    @(negedge clk);
    in_valid = 1'b0; op_a = rand_wide(); op_b = rand_wide(); sub = ~s;
    chk({tag, " add_a chunk0"}, add_a, a[N-1:0]);
    chk({tag, " add_b chunk0"}, add_b, beff[N-1:0]);
    chk({tag, " add_cin chunk0"}, add_cin, s);
    wait_valid(lat);
    chk({tag, " latency"}, lat, WORDS);
    chk({tag, " result"}, result, er);
    chk({tag, " carry"}, carry, ec);
    chk({tag, " overflow"}, overflow, eo);
    chk({tag, " zero"}, zero, ez);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, out_valid, 0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [W-1:0] er, a2, b2;
    logic ec, eo, ez;
    int lat;

    vecs[0] = '{a: 128'hFFFF_FFFF, b: 128'd1, s: 1'b0,
                r: 128'h1_0000_0000, c: 1'b0, o: 1'b0, z: 1'b0};
    vecs[1] = '{a: {W{1'b1}}, b: 128'd1, s: 1'b0,
                r: '0, c: 1'b1, o: 1'b0, z: 1'b1};
    vecs[2] = '{a: 128'd5, b: 128'd7, s: 1'b1,
                r: {{(W-2){1'b1}}, 2'b10}, c: 1'b0, o: 1'b0, z: 1'b0};
    vecs[3] = '{a: 128'd7, b: 128'd5, s: 1'b1,
                r: 128'd2, c: 1'b1, o: 1'b0, z: 1'b0};
    vecs[4] = '{a: {1'b0, {(W-1){1'b1}}}, b: 128'd1, s: 1'b0,
                r: {1'b1, {(W-1){1'b0}}}, c: 1'b0, o: 1'b1, z: 1'b0};
    vecs[5] = '{a: {1'b1, {(W-1){1'b0}}}, b: 128'd1, s: 1'b1,
                r: {1'b0, {(W-1){1'b1}}}, c: 1'b1, o: 1'b1, z: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; sub = 1'b0;

    #12;
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset flags", {carry, overflow, zero}, 0);
    chk("reset adder drive", {add_a, add_b, add_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after release", in_ready, 1);

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].o,
             vecs[i].z, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = rand_wide(); rb = rand_wide(); rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, er, ec, eo, ez);
      run_op(ra, rb, rs, er, ec, eo, ez, $sformatf("rand%0d", i));
    end

    // Backpressure: DONE held, inputs wiggle, then simultaneous in_valid/out_ready
    a2 = rand_wide(); b2 = rand_wide();
    model(a2, b2, 1'b1, er, ec, eo, ez);
    @(negedge clk);
    in_valid = 1'b1; op_a = a2; op_b = b2; sub = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp latency", lat, WORDS);
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      op_a = rand_wide();
      @(negedge clk);
      chk($sformatf("bp result c%0d", i), result, er);
      chk($sformatf("bp flags c%0d", i), {carry, overflow, zero}, {ec, eo, ez});
      chk($sformatf("bp valid/ready c%0d", i), {out_valid, in_ready}, 2'b10);
    end
    a2 = rand_wide(); b2 = rand_wide();
    model(a2, b2, 1'b0, er, ec, eo, ez);
    in_valid = 1'b1; op_a = a2; op_b = b2; sub = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp handshake not accepting", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp accepted next cycle", in_ready, 0);
    wait_valid(lat);
    chk("bp second latency", lat, WORDS);
    chk("bp second result", result, er);
    chk("bp second flags", {carry, overflow, zero}, {ec, eo, ez});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while idx == 2
    @(negedge clk);
    in_valid = 1'b1; op_a = {W{1'b1}}; op_b = {W{1'b1}}; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset result chunk0", result[N-1:0], 32'hFFFF_FFFE);
    rst_n = 1'b0;
    #1;
    chk("mid reset result", result, 0);
    chk("mid reset flags", {carry, overflow, zero}, 0);
    chk("mid reset valid/ready", {out_valid, in_ready}, 0);
    chk("mid reset adder drive", {add_a, add_b, add_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("post reset no valid c%0d", i), out_valid, 0);
    end
    a2 = rand_wide(); b2 = rand_wide();
    model(a2, b2, 1'b0, er, ec, eo, ez);
    run_op(a2, b2, 1'b0, er, ec, eo, ez, "post-reset add");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
